// File: rtl/abc_fetch_pkg.sv
// Shared types for the CoreABC instruction-fetch stage: default widths,
// fetch state encoding and the buffered {instr, pc} entry.
package abc_fetch_pkg;
  localparam int ABC_ADDR_W = 8;
  localparam int ABC_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ABC_DATA_W-1:0] instr;
    logic [ABC_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/abc_fetch_buf.sv
// Small tagged FIFO between the RAM read port and the decoder.
// Flush wins over a same-cycle push, so a word landing during a jump is lost.
module abc_fetch_buf
  import abc_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output fetch_entry_t       o_head,
  output logic [CW-1:0]      o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t      r_mem [DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = i_push & (r_cnt != CW'(DEPTH));
  assign w_pop   = i_pop & (r_cnt != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/abc_instr_fetch.sv
// CoreABC fetch stage: drives the 1-cycle-latency instruction RAM and hands
// {INSTR, INSTR_PC} to the decoder over valid/ready.
module abc_instr_fetch
  import abc_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ABC_ADDR_W,
  parameter int                    DATA_WIDTH = ABC_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  RWCLK,
  input  logic                  RESETN,
  input  logic                  RUN,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic                  REN,
  input  logic [DATA_WIDTH-1:0] RD,
  output logic [DATA_WIDTH-1:0] INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY
);
  localparam int BCW = $clog2(BUF_DEPTH + 1);
  localparam int OCW = BCW + 1;

  logic [ADDR_WIDTH-1:0] r_pc, r_tag, r_hold_pc;
  logic [DATA_WIDTH-1:0] r_hold_instr;
  logic                  r_inflight;
  fetch_state_t          r_state, w_state_nxt;

  fetch_entry_t          w_entry, w_head;
  logic [BCW-1:0]        w_count;
  logic [OCW-1:0]        w_occ;
  logic                  w_valid, w_pop, w_issue;

  assign w_valid = RESETN & (w_count != '0);
  assign w_pop   = w_valid & INSTR_READY;
  // Occupancy counts the word still in the RAM pipe; a jump empties everything.
  assign w_occ   = OCW'(w_count) + OCW'(r_inflight) - OCW'(w_pop);
  assign w_issue = RESETN & RUN & (JUMP | (w_occ < OCW'(BUF_DEPTH)));

  assign REN   = w_issue;
  assign RADDR = !RESETN ? RESET_PC : (JUMP ? JUMP_ADDR : r_pc);

  assign w_entry.instr = RD;
  assign w_entry.pc    = r_tag;

  abc_fetch_buf #(.DEPTH(BUF_DEPTH), .CW(BCW)) u_buf (
    .clk     (RWCLK),
    .rst_n   (RESETN),
    .i_push  (r_inflight),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (JUMP),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Outputs keep showing the last head once the buffer drains.
  assign INSTR_VALID = w_valid;
  assign INSTR    = !RESETN ? '0 : (w_valid ? w_head.instr : r_hold_instr);
  assign INSTR_PC = !RESETN ? '0 : (w_valid ? w_head.pc    : r_hold_pc);

  always_ff @(posedge RWCLK) begin
    if (!RESETN) begin
      r_pc         <= RESET_PC;
      r_tag        <= '0;
      r_inflight   <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_state      <= ST_IDLE;
    end else begin
      r_inflight <= w_issue;
      r_state    <= w_state_nxt;
      if (w_issue) r_tag <= RADDR;
      if (JUMP)         r_pc <= RUN ? JUMP_ADDR + 1'b1 : JUMP_ADDR;
      else if (w_issue) r_pc <= r_pc + 1'b1;
      if (w_valid) begin
        r_hold_instr <= w_head.instr;
        r_hold_pc    <= w_head.pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (RUN) w_state_nxt = ST_FETCH;
      ST_FETCH: if (!RUN) w_state_nxt = r_inflight ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: w_state_nxt = RUN ? ST_FETCH : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_abc_instr_fetch.sv
// Directed bench for abc_instr_fetch against a RAM model holding RAM[a]=a*3.
module tb_abc_instr_fetch;
  logic        clk = 1'b0;
  logic        rstn, run, jump, ready, ren, valid;
  logic [7:0]  jaddr, raddr, ipc;
  logic [15:0] rd, instr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  abc_instr_fetch dut (
    .RWCLK(clk), .RESETN(rstn), .RUN(run), .JUMP(jump), .JUMP_ADDR(jaddr),
    .RADDR(raddr), .REN(ren), .RD(rd), .INSTR(instr), .INSTR_PC(ipc),
    .INSTR_VALID(valid), .INSTR_READY(ready)
  );

  always @(posedge clk) if (ren) rd <= 16'({8'h00, raddr}) * 16'd3;

  typedef struct {
    logic        rstn, run, jump;
    logic [7:0]  ja;
    logic        ready, ren;
    logic [7:0]  raddr;
    logic        valid, chk;
    logic [15:0] instr;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rn, logic j, logic [7:0] ja, logic rdy,
                              logic en, logic [7:0] ra, logic v, logic c,
                              logic [15:0] i, logic [7:0] p);
    vec_t t;
    t.rstn = r; t.run = rn; t.jump = j; t.ja = ja; t.ready = rdy;
    t.ren = en; t.raddr = ra; t.valid = v; t.chk = c; t.instr = i; t.pc = p;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; run = 1'b0; jump = 1'b0; jaddr = '0; ready = 1'b0; rd = '0;

    // rst  run jmp ja  rdy  ren raddr vld chk instr pc
    // streaming from reset
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd0,  0,1,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd1,  0,0,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd2,  1,1,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd3,  1,1,16'd3,  8'd1));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd4,  1,1,16'd6,  8'd2));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd5,  1,1,16'd9,  8'd3));
    // decoder stall for 5 cycles
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,1,0,8'h00,0, k == 0 ? 1'b0 : 1'b0,8'd6, 1,1,16'd12,8'd4));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd6,  1,1,16'd12, 8'd4));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd7,  1,1,16'd15, 8'd5));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd8,  1,1,16'd18, 8'd6));
    // jump to 0x40 with buffer + inflight fully occupied
    vecs.push_back(mk(1,1,1,8'h40,0, 1,8'h40, 1,1,16'd21, 8'd7));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'h41, 0,1,16'd21, 8'd7));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'h42, 1,1,16'hC0, 8'h40));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'h43, 1,1,16'hC3, 8'h41));
    // jump to 254 while popping, then wrap
    vecs.push_back(mk(1,1,1,8'd254,1, 1,8'd254, 1,1,16'hC6, 8'h42));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd255, 0,1,16'hC6, 8'h42));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd0,   1,1,16'd762, 8'd254));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd1,   1,1,16'd765, 8'd255));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd2,   1,1,16'd0,   8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd3,   1,1,16'd3,   8'd1));
    // RUN low 3 cycles with a read inflight
    vecs.push_back(mk(1,0,0,8'h00,1, 0,8'd4,  1,1,16'd6,  8'd2));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,8'd4,  1,1,16'd9,  8'd3));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,8'd4,  0,1,16'd9,  8'd3));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd4,  0,1,16'd9,  8'd3));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd5,  0,1,16'd9,  8'd3));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd6,  1,1,16'd12, 8'd4));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd7,  1,1,16'd15, 8'd5));
    // jump while stopped: PC takes the target without issuing
    vecs.push_back(mk(1,0,1,8'h10,1, 0,8'h10, 1,1,16'd18, 8'd6));
    vecs.push_back(mk(1,0,0,8'h00,1, 0,8'h10, 0,1,16'd18, 8'd6));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'h10, 0,1,16'd18, 8'd6));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'h11, 0,1,16'd18, 8'd6));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'h12, 1,1,16'h30, 8'h10));
    // reset mid-stream with JUMP asserted
    vecs.push_back(mk(0,1,1,8'h80,1, 0,8'h00, 0,1,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd0,  0,1,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd1,  0,1,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd2,  1,1,16'd0,  8'd0));
    vecs.push_back(mk(1,1,0,8'h00,1, 1,8'd3,  1,1,16'd3,  8'd1));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ren",   -1, 32'(ren),   32'd0);
    chk("rst_raddr", -1, 32'(raddr), 32'd0);
    chk("rst_valid", -1, 32'(valid), 32'd0);
    chk("rst_instr", -1, 32'(instr), 32'd0);
    chk("rst_pc",    -1, 32'(ipc),   32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rstn = vecs[i].rstn; run = vecs[i].run; jump = vecs[i].jump;
      jaddr = vecs[i].ja; ready = vecs[i].ready;
      #1;
      chk("ren",   i, 32'(ren),   32'(vecs[i].ren));
      chk("raddr", i, 32'(raddr), 32'(vecs[i].raddr));
      chk("valid", i, 32'(valid), 32'(vecs[i].valid));
      if (vecs[i].chk) begin
        chk("instr",    i, 32'(instr), 32'(vecs[i].instr));
        chk("instr_pc", i, 32'(ipc),   32'(vecs[i].pc));
      end
    end

    // sustained throughput: one instruction every cycle, strictly in order
    for (int k = 0; k < 12; k++) begin
      logic [7:0] epc;
      epc = 8'(k + 2);
      @(negedge clk);
      rstn = 1'b1; run = 1'b1; jump = 1'b0; ready = 1'b1;
      #1;
      chk("tp_valid", 100 + k, 32'(valid), 32'd1);
      chk("tp_pc",    100 + k, 32'(ipc),   32'(epc));
      chk("tp_instr", 100 + k, 32'(instr), 32'(16'({8'h00, epc}) * 16'd3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
